// File: rtl/matrix_read_sm.sv
// matrix_read_sm: sequential sweep reader for the cache matrix memory.
// Issues one read per set (0..SET_AMOUNT-1) and streams each returned row,
// tagged with its set address, through a 2-entry valid/ready output buffer.
// Optional build macro MATRIX_READ_CHECK_EN adds an all-ones compare of every
// captured row with a sticky error flag and first-mismatch address.

package cache_pkg;
  localparam int MATRIX_WIDTH = 32;
  localparam int SET_BITS     = 4;
  localparam int SET_AMOUNT   = 16;
endpackage

module matrix_read_sm
  import cache_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    sel_o,
  output logic                    we_o,
  output logic [SET_BITS-1:0]     addr_o,
  input  logic [MATRIX_WIDTH-1:0] vect_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [MATRIX_WIDTH-1:0] out_vect_o,
  output logic [SET_BITS-1:0]     out_addr_o,
  output logic                    err_o,
  output logic [SET_BITS-1:0]     err_addr_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [SET_BITS:0] LAST_SET = (SET_BITS+1)'(SET_AMOUNT - 1);

  state_t                  state_q, state_d;
  logic [SET_BITS:0]       rd_cnt_q, rd_cnt_d;
  logic                    done_q, done_d;
  logic                    inflight_q;
  logic [SET_BITS-1:0]     inflight_addr_q;
  logic [1:0]              count_q, count_d;
  logic                    wr_ptr_q, rd_ptr_q;
  logic [MATRIX_WIDTH-1:0] buf_vect_q [2];
  logic [SET_BITS-1:0]     buf_addr_q [2];

  logic       push, pop, issue;
  logic [2:0] occ;

  // Buffer occupancy bookkeeping and read-issue decision.
  always_comb begin
    push    = inflight_q;
    pop     = (count_q != 2'd0) && out_ready_i;
    // Slots that will be claimed next cycle if no new read goes out now.
    occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue   = (state_q == RUN) && (occ < 3'd2);
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // Next-state logic for the sweep controller.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RUN;
          rd_cnt_d = '0;
        end
      end
      RUN: begin
        if (issue) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == LAST_SET) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // No reads are issued here, so an empty next-cycle buffer means
        // nothing is left in flight either.
        if (count_d == 2'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers: state, counters, in-flight flag and FIFO pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      done_q     <= done_d;
      inflight_q <= issue;
      count_q    <= count_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Data registers: read address delay line and buffer storage.
  always_ff @(posedge clk_i) begin
    inflight_addr_q <= addr_o;
    if (push) begin
      buf_vect_q[wr_ptr_q] <= vect_i;
      buf_addr_q[wr_ptr_q] <= inflight_addr_q;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign sel_o       = issue;
  assign we_o        = 1'b0;
  assign addr_o      = rd_cnt_q[SET_BITS-1:0];
  assign out_valid_o = (count_q != 2'd0);
  // Storage is not reset, so the head is masked while the buffer is empty.
  assign out_vect_o  = out_valid_o ? buf_vect_q[rd_ptr_q] : '0;
  assign out_addr_o  = out_valid_o ? buf_addr_q[rd_ptr_q] : '0;

`ifdef MATRIX_READ_CHECK_EN
  logic                err_q;
  logic [SET_BITS-1:0] err_addr_q;
  logic                start_acc;

  assign start_acc = (state_q == IDLE) && start_i;

  // Sticky first-mismatch capture against the initialized all-ones row.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_acc) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (push && !err_q && (vect_i != {MATRIX_WIDTH{1'b1}})) begin
      err_q      <= 1'b1;
      err_addr_q <= inflight_addr_q;
    end
  end

  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;
`else
  assign err_o      = 1'b0;
  assign err_addr_o = '0;
`endif

endmodule

// File: tb/tb_matrix_read_sm.sv
// Randomized self-checking bench for matrix_read_sm with a behavioural
// memory model and an order/occupancy scoreboard sampled on the falling edge.
module tb_matrix_read_sm;
  import cache_pkg::*;

  localparam int N = SET_AMOUNT;
  localparam int BOUND = 400;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b1;
  logic                    start_i = 1'b0;
  logic                    out_ready_i = 1'b0;
  logic [MATRIX_WIDTH-1:0] vect_i = '0;
  logic                    busy_o, done_o, sel_o, we_o, out_valid_o, err_o;
  logic [SET_BITS-1:0]     addr_o, out_addr_o, err_addr_o;
  logic [MATRIX_WIDTH-1:0] out_vect_o;

  matrix_read_sm dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o),
    .done_o(done_o), .sel_o(sel_o), .we_o(we_o), .addr_o(addr_o),
    .vect_i(vect_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_vect_o(out_vect_o), .out_addr_o(out_addr_o), .err_o(err_o),
    .err_addr_o(err_addr_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory contents: 0 = set index replicated, 1 = ones with holes at 3 and 7, 2 = all ones.
  int mem_mode = 0;

  function automatic logic [MATRIX_WIDTH-1:0] pat(input int a);
    logic [SET_BITS-1:0] aa;
    aa = a[SET_BITS-1:0];
    case (mem_mode)
      0:       return {(MATRIX_WIDTH/SET_BITS){aa}};
      1:       return (a == 3 || a == 7) ? '0 : '1;
      default: return '1;
    endcase
  endfunction

  // Expected sticky error after a full sweep: first set whose row is not all ones.
  task automatic exp_err(output bit e, output int ea);
    e = 1'b0;
    ea = 0;
`ifdef MATRIX_READ_CHECK_EN
    for (int a = 0; a < N; a++)
      if (!e && pat(a) != {MATRIX_WIDTH{1'b1}}) begin
        e = 1'b1;
        ea = a;
      end
`endif
  endtask

  // Memory: data answers one cycle after a select; garbage otherwise.
  always @(posedge clk_i)
    vect_i <= sel_o ? pat(int'(addr_o)) : MATRIX_WIDTH'($urandom);

  int sel_cnt = 0, pop_cnt = 0, done_cnt = 0, exp_next = 0;
  bit stalled = 0;
  logic [SET_BITS-1:0]     hold_addr;
  logic [MATRIX_WIDTH-1:0] hold_vect;

  // Scoreboard: read order, element order/content, stall stability, occupancy.
  always @(negedge clk_i) begin
    if (rst_i) begin
      stalled = 0;
    end else begin
      if (sel_o) begin
        check("sel_addr", addr_o, sel_cnt % N);
        check("we", we_o, 0);
        sel_cnt++;
      end
      if (done_o) done_cnt++;
      if (out_valid_o) begin
        if (stalled) begin
          check("hold_addr", out_addr_o, hold_addr);
          check("hold_vect", out_vect_o, hold_vect);
        end
        if (out_ready_i) begin
          check("pop_addr", out_addr_o, exp_next % N);
          check("pop_vect", out_vect_o, pat(exp_next % N));
          exp_next++;
          pop_cnt++;
        end
        stalled = !out_ready_i;
        hold_addr = out_addr_o;
        hold_vect = out_vect_o;
      end else begin
        stalled = 0;
      end
      check("outstanding_le2", (sel_cnt - pop_cnt) <= 2, 1);
    end
  end

  function automatic logic rdy(input int mode, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom % 2);
      default: return n > 10;
    endcase
  endfunction

  task automatic clear_model();
    sel_cnt = 0;
    pop_cnt = 0;
    done_cnt = 0;
    exp_next = 0;
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_busy"}, busy_o, 0);
    check({nm, "_done"}, done_o, 0);
    check({nm, "_sel"}, sel_o, 0);
    check({nm, "_we"}, we_o, 0);
    check({nm, "_addr"}, addr_o, 0);
    check({nm, "_valid"}, out_valid_o, 0);
    check({nm, "_ovect"}, out_vect_o, 0);
    check({nm, "_oaddr"}, out_addr_o, 0);
    check({nm, "_err"}, err_o, 0);
    check({nm, "_err_addr"}, err_addr_o, 0);
  endtask

  // One complete sweep with the given backpressure mode and memory contents.
  task automatic sweep(input string nm, input int rmode, input bit poke, input int mmode);
    int n;
    int first_v;
    bit e;
    int ea;
    mem_mode = mmode;
    clear_model();
    first_v = -1;
    @(posedge clk_i); #1;
    start_i = 1'b1;
    out_ready_i = rdy(rmode, 0);
    n = 0;
    while (!done_o && n < BOUND) begin
      @(posedge clk_i); n++; #1;
      start_i = poke && (n == 5);
      out_ready_i = rdy(rmode, n);
      if (n == 1) check({nm, "_err_clr"}, err_o, 0);
      if (out_valid_o && first_v < 0) first_v = n;
      if (rmode == 2 && n == 10) begin
        check({nm, "_stall_sels"}, sel_cnt, 2);
        check({nm, "_stall_valid"}, out_valid_o, 1);
        check({nm, "_stall_head"}, out_addr_o, 0);
      end
    end
    start_i = 1'b0;
    if (n >= BOUND) begin
      check({nm, "_timeout"}, n, 0);
    end else begin
      check({nm, "_busy_at_done"}, busy_o, 0);
      if (rmode == 0) begin
        check({nm, "_latency"}, n, N + 3);
        check({nm, "_first_valid"}, first_v, 3);
      end
    end
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check({nm, "_done_pulses"}, done_cnt, 1);
    check({nm, "_pops"}, pop_cnt, N);
    check({nm, "_sels"}, sel_cnt, N);
    check({nm, "_idle_valid"}, out_valid_o, 0);
    exp_err(e, ea);
    check({nm, "_err"}, err_o, e);
    check({nm, "_err_addr"}, err_addr_o, ea);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk_i);
    #1;
    check_zero("reset");
    rst_i = 1'b0;

    sweep("free", 0, 0, 0);
    sweep("stall", 2, 0, 0);
    sweep("rand", 1, 0, 0);
    sweep("busy_start", 1, 1, 0);

    // Reset while the read for set 5 is being issued.
    mem_mode = 0;
    clear_model();
    @(posedge clk_i); #1;
    start_i = 1'b1;
    out_ready_i = 1'b1;
    n = 0;
    while (!(sel_o && addr_o == 5) && n < BOUND) begin
      @(posedge clk_i); n++; #1;
      start_i = 1'b0;
    end
    check("rst_reach_addr5", n < BOUND, 1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check_zero("rst_mid");
    rst_i = 1'b0;
    repeat (2) begin
      @(posedge clk_i); #1;
      check("rst_discard_valid", out_valid_o, 0);
      check("rst_no_done", done_o, 0);
    end
    sweep("after_rst", 0, 0, 0);

    sweep("chk", 0, 0, 1);
    sweep("ones", 1, 0, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/matrix_read_sm.md
# matrix_read_sm

Sequential reader for the cache matrix memory, the counterpart of the post-reset initialization writer. After start, it sweeps every set from address 0 to SET_AMOUNT-1, issues one read per set, and streams each returned row vector with its set address out on a valid/ready interface. A 2-entry output buffer provides full backpressure. It sits between the matrix memory read port and consumers such as flush, debug dump or initialization checking.

## Interface
- No module parameters. Widths and limits come from `cache_pkg`:
  - MATRIX_WIDTH: width of one matrix row.
  - SET_BITS: set index width.
  - SET_AMOUNT: number of sets.
- clk_i  in  1  single clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  begin a sweep; sampled only in IDLE
- busy_o  out  1  high in RUN and DRAIN
- done_o  out  1  one-cycle pulse when the last element is accepted downstream
- sel_o  out  1  memory select; high for exactly one cycle per read issued
- we_o  out  1  memory write enable; constant 0
- addr_o  out  SET_BITS  set address of the current read
- vect_i  in  MATRIX_WIDTH  memory read data; valid the cycle after sel_o
- out_valid_o  out  1  output element available
- out_ready_i  in  1  consumer accepts the element
- out_vect_o  out  MATRIX_WIDTH  row vector of the head element
- out_addr_o  out  SET_BITS  set address of the head element
- err_o  out  1  sticky mismatch flag (see Configuration)
- err_addr_o  out  SET_BITS  address of the first mismatch

## Operation
- States:
  - IDLE: waits for start_i; start_i high moves to RUN.
  - RUN: issues reads. After the read for set SET_AMOUNT-1 is issued, moves to DRAIN.
  - DRAIN: waits until nothing is in flight and the buffer is empty, pulses done_o, and returns to IDLE.
- Read counter rd_cnt is SET_BITS+1 wide:
  - Cleared on start.
  - Incremented on each read issued.
  - addr_o = rd_cnt[SET_BITS-1:0].
- Read issue rule, each RUN cycle:
  - issue = (buf_count + inflight - pop) < 2, where pop = out_valid_o & out_ready_i.
  - Reads never exceed buffer space, so no data is dropped.
- Returned data is captured into the buffer together with its address, delayed one cycle from addr_o.
- The buffer is a 2-entry FIFO and the head drives the out_* ports.
  - Push and pop in the same cycle are legal: count is unchanged and order is preserved.
- Elements are emitted in strictly ascending address order, exactly SET_AMOUNT elements per sweep.
- start_i is ignored while busy_o=1.
- Reset mid-sweep:
  - Next cycle: IDLE, buffer empty, inflight=0, rd_cnt=0.
  - sel_o=0, out_valid_o=0, and no done_o pulse.
  - err_o and err_addr_o are cleared.
  - Memory data returning after reset is discarded.

## Timing
- Reset values of all outputs are 0: busy_o, done_o, sel_o, we_o, addr_o, out_valid_o, out_vect_o, out_addr_o, err_o, err_addr_o.
- start_i accepted at edge E0: sel_o=1 with addr_o=0 in the cycle after E0.
- vect_i is sampled at the end of the following cycle. out_valid_o rises in the cycle after that.
  - start-to-first-valid latency is 3 cycles.
- With out_ready_i held at 1:
  - One read and one element per cycle.
  - The full sweep, from start to done_o, takes SET_AMOUNT+3 cycles.
- With out_ready_i held at 0:
  - Exactly 2 reads are issued, then sel_o stays low until a pop occurs.
  - out_* stay stable while out_valid_o=1 and out_ready_i=0.
- done_o is asserted in the cycle after the final pop. busy_o falls in the same cycle.

## Configuration
- Macro: MATRIX_READ_CHECK_EN.
- When defined:
  - Each captured vector is compared against all-ones, the initialized value.
  - On the first mismatch of a sweep, err_o is set and stays set, and err_addr_o latches that set address.
  - Later mismatches in the same sweep do not change err_addr_o.
  - Both are cleared on an accepted start_i or on reset.
  - The check does not alter streaming.
- When undefined: err_o and err_addr_o are tied to 0 and no compare logic is built.

## Test plan
- Sweep with no backpressure:
  - Stimulus: memory model returns vect = {addr replicated}; out_ready_i=1; start_i pulsed.
  - Required: SET_AMOUNT elements with addresses 0..SET_AMOUNT-1 in order and matching vectors; done_o exactly SET_AMOUNT+3 cycles after start.
- Full stall:
  - Stimulus: out_ready_i=0 for 10 cycles after start.
  - Required: exactly 2 sel_o pulses (addr 0 and 1); head stays at addr 0.
  - After release: no lost or duplicated element.
- Random backpressure:
  - Stimulus: out_ready_i random at 50%.
  - Required: full in-order set of elements; sel_o count equals SET_AMOUNT; buffer never overflows.
- Start while busy:
  - Stimulus: start_i pulsed during RUN.
  - Required: ignored; exactly one done_o pulse.
- Reset at address 5:
  - Stimulus: rst_i asserted when addr_o=5.
  - Required: all outputs 0 next cycle.
  - A new start then sweeps from addr 0.
- Check mode (MATRIX_READ_CHECK_EN defined):
  - Stimulus: memory returns all-ones except 0 at sets 3 and 7.
  - Required: err_o=1 and err_addr_o=3 after the sweep; cleared by the next start.
